// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: state encoding, opcodes
// and the fixed IR capture pattern.
package jtag_pkg;

   typedef enum logic [3:0] {
      TLR    = 4'd0,
      RTI    = 4'd1,
      SEL_DR = 4'd2,
      CAP_DR = 4'd3,
      SH_DR  = 4'd4,
      EX1_DR = 4'd5,
      PAU_DR = 4'd6,
      EX2_DR = 4'd7,
      UPD_DR = 4'd8,
      SEL_IR = 4'd9,
      CAP_IR = 4'd10,
      SH_IR  = 4'd11,
      EX1_IR = 4'd12,
      PAU_IR = 4'd13,
      EX2_IR = 4'd14,
      UPD_IR = 4'd15
   } tap_state_e;

   typedef enum logic [1:0] {
      DR_BYPASS = 2'd0,
      DR_IDCODE = 2'd1,
      DR_USER   = 2'd2
   } dr_sel_e;

   // Truncated to IR_LENGTH at the point of use
   localparam logic [31:0] OP_BYPASS = '1;
   localparam int OP_IDCODE          = 1;
   localparam int OP_USER_BASE       = 2;
   localparam int IDCODE_LENGTH      = 32;

   localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state register and next-state logic.
// TMS-driven, synchronous TRST to TEST_LOGIC_RESET.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       TCK,
   input  logic       TRST,
   input  logic       TMS,
   output tap_state_e tap_state
);

   tap_state_e state_nxt;

   always_comb begin
      state_nxt = tap_state;
      case (tap_state)
         TLR:     state_nxt = TMS ? TLR    : RTI;
         RTI:     state_nxt = TMS ? SEL_DR : RTI;
         SEL_DR:  state_nxt = TMS ? SEL_IR : CAP_DR;
         CAP_DR:  state_nxt = TMS ? EX1_DR : SH_DR;
         SH_DR:   state_nxt = TMS ? EX1_DR : SH_DR;
         EX1_DR:  state_nxt = TMS ? UPD_DR : PAU_DR;
         PAU_DR:  state_nxt = TMS ? EX2_DR : PAU_DR;
         EX2_DR:  state_nxt = TMS ? UPD_DR : SH_DR;
         UPD_DR:  state_nxt = TMS ? SEL_DR : RTI;
         SEL_IR:  state_nxt = TMS ? TLR    : CAP_IR;
         CAP_IR:  state_nxt = TMS ? EX1_IR : SH_IR;
         SH_IR:   state_nxt = TMS ? EX1_IR : SH_IR;
         EX1_IR:  state_nxt = TMS ? UPD_IR : PAU_IR;
         PAU_IR:  state_nxt = TMS ? EX2_IR : PAU_IR;
         EX2_IR:  state_nxt = TMS ? UPD_IR : SH_IR;
         UPD_IR:  state_nxt = TMS ? SEL_DR : RTI;
         default: state_nxt = TLR;
      endcase
   end

   always_ff @(posedge TCK) begin
      if (TRST) tap_state <= TLR;
      else      tap_state <= state_nxt;
   end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// Parametrised JTAG TAP: IR, BYPASS, IDCODE and user DRs
// with parallel capture/update and falling-edge TDO.
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter int          IR_LENGTH      = 4,
   parameter int          NUM_USER_DR    = 2,
   parameter int          USER_DR_LENGTH = 8,
   parameter logic [31:0] IDCODE_VALUE   = 32'h1000_0001
) (
   input  logic                                  TCK,
   input  logic                                  TRST,
   input  logic                                  TMS,
   input  logic                                  TDI,
   output logic                                  TDO,
   output logic                                  TDO_EN,
   output logic [IR_LENGTH-1:0]                  ir_value,
   output logic [3:0]                            tap_state,
   input  logic [NUM_USER_DR*USER_DR_LENGTH-1:0] user_capture_data,
   output logic [NUM_USER_DR*USER_DR_LENGTH-1:0] user_update_data,
   output logic [NUM_USER_DR-1:0]                user_update_strobe
);

   localparam int UL = USER_DR_LENGTH;

   tap_state_e state;

   logic [IR_LENGTH-1:0]     ir_sr;
   logic [IR_LENGTH-1:0]     ir_cap;
   logic [IR_LENGTH-1:0]     ir_shift;
   logic                     bypass_sr;
   logic [IDCODE_LENGTH-1:0] idcode_sr;
   logic [UL-1:0]            user_sr;
   logic [UL-1:0]            user_shift;
   logic [UL-1:0]            user_cap;
   logic [NUM_USER_DR-1:0]   sel_user;
   dr_sel_e                  dr_sel;
   logic                     dr_lsb;
   logic                     regs_rst;

   jtag_tap_fsm u_fsm (
      .TCK       (TCK),
      .TRST      (TRST),
      .TMS       (TMS),
      .tap_state (state)
   );

   assign tap_state = state;

   // Register reset on TRST and on every edge that lands in TLR
   assign regs_rst = TRST
                   | (TMS & ((state == TLR) | (state == SEL_IR)));

   assign ir_cap   = IR_LENGTH'(IR_CAPTURE_PAT);
   assign ir_shift = {TDI, ir_sr[IR_LENGTH-1:1]};

   if (UL > 1) begin : g_ush
      assign user_shift = {TDI, user_sr[UL-1:1]};
   end else begin : g_ush1
      assign user_shift = TDI;
   end

   always_comb begin
      sel_user = '0;
      for (int k = 0; k < NUM_USER_DR; k++) begin
         sel_user[k] = (ir_value == IR_LENGTH'(OP_USER_BASE + k));
      end
   end

   always_comb begin
      user_cap = '0;
      for (int k = 0; k < NUM_USER_DR; k++) begin
         if (sel_user[k]) user_cap = user_capture_data[k*UL +: UL];
      end
   end

   // Unassigned opcodes fall through to BYPASS
   always_comb begin
      dr_sel = DR_BYPASS;
      unique case (1'b1)
         (ir_value == OP_BYPASS[IR_LENGTH-1:0]):  dr_sel = DR_BYPASS;
         (ir_value == IR_LENGTH'(OP_IDCODE)):     dr_sel = DR_IDCODE;
         (|sel_user):                             dr_sel = DR_USER;
         default:                                 dr_sel = DR_BYPASS;
      endcase
   end

   always_comb begin
      dr_lsb = bypass_sr;
      unique case (dr_sel)
         DR_IDCODE: dr_lsb = idcode_sr[0];
         DR_USER:   dr_lsb = user_sr[0];
         default:   dr_lsb = bypass_sr;
      endcase
   end

   always_ff @(posedge TCK) begin
      if (regs_rst) begin
         ir_sr              <= '0;
         ir_value           <= IR_LENGTH'(OP_IDCODE);
         bypass_sr          <= 1'b0;
         idcode_sr          <= '0;
         user_sr            <= '0;
         user_update_data   <= '0;
         user_update_strobe <= '0;
      end else begin
         user_update_strobe <= '0;
         case (state)
            CAP_IR: ir_sr    <= ir_cap;
            SH_IR:  ir_sr    <= ir_shift;
            UPD_IR: ir_value <= ir_sr;
            CAP_DR: begin
               unique case (dr_sel)
                  DR_IDCODE: idcode_sr <= IDCODE_VALUE;
                  DR_USER:   user_sr   <= user_cap;
                  default:   bypass_sr <= 1'b0;
               endcase
            end
            SH_DR: begin
               unique case (dr_sel)
                  DR_IDCODE: idcode_sr <= {TDI, idcode_sr[IDCODE_LENGTH-1:1]};
                  DR_USER:   user_sr   <= user_shift;
                  default:   bypass_sr <= TDI;
               endcase
            end
            UPD_DR: begin
               for (int k = 0; k < NUM_USER_DR; k++) begin
                  if (sel_user[k]) begin
                     user_update_data[k*UL +: UL] <= user_sr;
                     user_update_strobe[k]        <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(negedge TCK) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
      if (state == SH_IR) begin
         TDO    <= ir_sr[0];
         TDO_EN <= 1'b1;
      end else if (state == SH_DR) begin
         TDO    <= dr_lsb;
         TDO_EN <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: scoreboarded TDO
// streams plus IR/update/strobe checks.
module tb_jtag_tap_ctrl;
   import jtag_pkg::*;

   localparam int IRL = 4;
   localparam int NU  = 2;
   localparam int UL  = 8;
   localparam logic [31:0] IDC = 32'h1000_0001;

   logic           TCK = 1'b0;
   logic           TRST = 1'b0;
   logic           TMS = 1'b1;
   logic           TDI = 1'b0;
   logic           TDO;
   logic           TDO_EN;
   logic [IRL-1:0] ir_value;
   logic [3:0]     tap_state;
   logic [NU*UL-1:0] user_capture_data = '0;
   logic [NU*UL-1:0] user_update_data;
   logic [NU-1:0]    user_update_strobe;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic exp_q[$];

   always #5 TCK = ~TCK;

   jtag_tap_ctrl #(
      .IR_LENGTH      (IRL),
      .NUM_USER_DR    (NU),
      .USER_DR_LENGTH (UL),
      .IDCODE_VALUE   (IDC)
   ) dut (
      .TCK                (TCK),
      .TRST               (TRST),
      .TMS                (TMS),
      .TDI                (TDI),
      .TDO                (TDO),
      .TDO_EN             (TDO_EN),
      .ir_value           (ir_value),
      .tap_state          (tap_state),
      .user_capture_data  (user_capture_data),
      .user_update_data   (user_update_data),
      .user_update_strobe (user_update_strobe)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change just after the falling edge; outputs sampled there too
   task automatic tck(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      @(negedge TCK);
      #1;
   endtask

   // Reference shift register: TDI enters MSB, LSB leaves first
   task automatic model_push(input int len, input logic [63:0] cap,
                             input logic [63:0] din, input int n);
      logic [63:0] m;
      m = cap;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(m[0]);
         m = m >> 1;
         m[len-1] = din[i];
      end
   endtask

   task automatic shift_bits(input string tag, input int n,
                             input logic [63:0] din, input int off,
                             input logic last_tms);
      for (int i = 0; i < n; i++) begin
         logic e;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
         check($sformatf("%s tdo[%0d]", tag, off + i), TDO, e);
         check($sformatf("%s en[%0d]", tag, off + i), TDO_EN, 1);
         tck(last_tms && (i == n - 1), din[off+i]);
      end
   endtask

   task automatic enter_shdr(input string tag);
      tck(1, 0);
      tck(0, 0);
      check({tag, " cap_dr"}, tap_state, CAP_DR);
      check({tag, " cap en"}, TDO_EN, 0);
      tck(0, 0);
      check({tag, " sh_dr"}, tap_state, SH_DR);
   endtask

   task automatic load_ir(input logic [IRL-1:0] op);
      tck(1, 0);
      tck(1, 0);
      tck(0, 0);
      tck(0, 0);
      check("ir sh_ir", tap_state, SH_IR);
      model_push(IRL, 64'h1, {60'b0, op}, IRL);
      shift_bits("ir", IRL, {60'b0, op}, 0, 1'b1);
      check("ir ex1", tap_state, EX1_IR);
      tck(1, 0);
      tck(0, 0);
      check($sformatf("ir_value %0h", op), ir_value, op);
   endtask

   task automatic finish_update(input string tag,
                                input logic [NU-1:0] exp_stb,
                                input logic [NU*UL-1:0] exp_data);
      tck(1, 0);
      check({tag, " upd state"}, tap_state, UPD_DR);
      check({tag, " pre stb"}, user_update_strobe, 0);
      tck(0, 0);
      check({tag, " stb"}, user_update_strobe, exp_stb);
      check({tag, " data"}, user_update_data, exp_data);
      tck(0, 0);
      check({tag, " stb off"}, user_update_strobe, 0);
   endtask

   initial begin
      logic [NU-1:0] stb_seen;

      // 1: reset, IDCODE read
      TRST = 1'b1;
      tck(1, 0);
      TRST = 1'b0;
      check("rst state", tap_state, TLR);
      check("rst ir", ir_value, 4'b0001);
      check("rst tdo", TDO, 0);
      check("rst en", TDO_EN, 0);
      check("rst data", user_update_data, 0);
      check("rst stb", user_update_strobe, 0);
      tck(0, 0);
      check("rti", tap_state, RTI);
      enter_shdr("idc");
      model_push(32, {32'b0, IDC}, 64'h0, 32);
      shift_bits("idcode", 32, 64'h0, 0, 1'b1);
      check("idc ex1", tap_state, EX1_DR);
      check("idc ex1 en", TDO_EN, 0);

      // 2: back into SH_DR, then five TMS=1 to TLR
      tck(0, 0);
      tck(1, 0);
      tck(0, 0);
      check("resume sh", tap_state, SH_DR);
      check("resume en", TDO_EN, 1);
      stb_seen = '0;
      for (int i = 0; i < 5; i++) begin
         tck(1, 0);
         stb_seen |= user_update_strobe;
      end
      check("tms5 state", tap_state, TLR);
      check("tms5 ir", ir_value, 4'b0001);
      check("tms5 en", TDO_EN, 0);
      check("tms5 stb", stb_seen, 0);

      // 3: BYPASS one-bit delay
      tck(0, 0);
      load_ir(4'b1111);
      enter_shdr("byp");
      model_push(1, 64'h0, 64'b1101, 4);
      shift_bits("bypass", 4, 64'b1101, 0, 1'b1);
      finish_update("byp", 2'b00, 16'h0000);

      // 4: USER0 capture/update
      user_capture_data = 16'h00A5;
      load_ir(4'b0010);
      enter_shdr("u0");
      model_push(UL, 64'hA5, 64'h3C, UL);
      shift_bits("user0", UL, 64'h3C, 0, 1'b1);
      finish_update("u0", 2'b01, 16'h003C);

      // 5: USER1 with pause and no recapture on resume
      user_capture_data = 16'h5AA5;
      load_ir(4'b0011);
      enter_shdr("u1");
      model_push(UL, 64'h5A, 64'hC3, UL);
      shift_bits("user1a", 4, 64'hC3, 0, 1'b1);
      tck(0, 0);
      user_capture_data = 16'hFFA5;
      tck(0, 0);
      tck(0, 0);
      check("pause state", tap_state, PAU_DR);
      check("pause en", TDO_EN, 0);
      tck(1, 0);
      tck(0, 0);
      check("ex2 resume", tap_state, SH_DR);
      shift_bits("user1b", 4, 64'hC3, 4, 1'b1);
      finish_update("u1", 2'b10, 16'hC33C);

      // zero-shift update takes the captured value
      user_capture_data = 16'hFF99;
      load_ir(4'b0010);
      tck(1, 0);
      tck(0, 0);
      tck(1, 0);
      check("zs ex1", tap_state, EX1_DR);
      finish_update("zs", 2'b01, 16'hC399);

      // 6: TMS entry to TLR clears update data; TRST mid-shift
      for (int i = 0; i < 5; i++) tck(1, 0);
      check("tlr2 state", tap_state, TLR);
      check("tlr2 data", user_update_data, 0);
      tck(0, 0);
      load_ir(4'b0010);
      enter_shdr("part");
      model_push(UL, 64'h99, 64'hFF, 3);
      shift_bits("part", 3, 64'hFF, 0, 1'b0);
      TRST = 1'b1;
      tck(0, 1);
      TRST = 1'b0;
      check("trst state", tap_state, TLR);
      check("trst ir", ir_value, 4'b0001);
      check("trst stb", user_update_strobe, 0);
      check("trst data", user_update_data, 0);
      check("trst en", TDO_EN, 0);
      tck(0, 0);
      tck(0, 0);
      check("post trst stb", user_update_strobe, 0);
      check("post trst data", user_update_data, 0);

      // illegal opcode acts as BYPASS
      load_ir(4'b0111);
      enter_shdr("ill");
      model_push(1, 64'h0, 64'b101, 3);
      shift_bits("illegal", 3, 64'b101, 0, 1'b1);
      finish_update("ill", 2'b00, 16'h0000);

      check("sb empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
